mac_requant: RTL and testbench

MAC_REQUANT -- requirements
Module: mac_requant

---
 rtl/mac_requant.sv | 135 +++++++++++++
 tb/tb_mac_requant.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/mac_requant.sv
`default_nettype none
// ============================================================================
//  Module      : mac_requant
//  Description : Bias-preloaded signed multiply-accumulate over NUM_TERMS
//                terms followed by round-half-up requantization and
//                saturation back to a DATA_WIDTH fixed-point word.
//  Revision    : 1.0 - initial release
// ============================================================================
module mac_requant #(
  parameter int DATA_WIDTH = 14,
  parameter int FRAC_BITS  = 7,
  parameter int NUM_TERMS  = 9,
  parameter int ACC_WIDTH  = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         clear,
  input  logic                         in_valid,
  input  logic signed [DATA_WIDTH-1:0] act_in,
  input  logic signed [DATA_WIDTH-1:0] weight_in,
  input  logic signed [DATA_WIDTH-1:0] bias_in,
  output logic signed [DATA_WIDTH-1:0] data_out,
  output logic                         valid,
  output logic                         busy
);

  // Counter must be able to hold NUM_TERMS-1 (the index of the last term).
  localparam int CNT_W = (NUM_TERMS > 1) ? $clog2(NUM_TERMS) : 1;
  localparam int PROD_W = 2 * DATA_WIDTH;

  // Rounding offset: one half LSB of the output format, expressed in
  // accumulator (2*FRAC_BITS) scaling.
  localparam logic signed [ACC_WIDTH-1:0] c_half =
    ACC_WIDTH'(1) << (FRAC_BITS - 1);

  // Saturation limits of the output word, sign-extended to accumulator width.
  localparam logic signed [ACC_WIDTH-1:0] c_max =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] c_min =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  localparam logic [CNT_W-1:0] c_last_term = CNT_W'(NUM_TERMS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_ROUND = 2'd2
  } state_t;

  state_t                        r_state;
  logic signed [ACC_WIDTH-1:0]   r_acc;
  logic        [CNT_W-1:0]       r_count;

  logic signed [PROD_W-1:0]      w_prod;
  logic signed [ACC_WIDTH-1:0]   w_prod_ext;
  logic signed [ACC_WIDTH-1:0]   w_bias_ext;
  logic signed [ACC_WIDTH-1:0]   w_bias_acc;
  logic signed [ACC_WIDTH-1:0]   w_rounded;
  logic signed [ACC_WIDTH-1:0]   w_shifted;
  logic signed [DATA_WIDTH-1:0]  w_sat;

  // Datapath: full-precision product, bias alignment, rounding and clamping.
  always_comb begin
    w_prod     = act_in * weight_in;
    w_prod_ext = {{(ACC_WIDTH-PROD_W){w_prod[PROD_W-1]}}, w_prod};
    // Bias shares the activation format, so it is moved up by FRAC_BITS to
    // line up with the product scaling before it seeds the accumulator.
    w_bias_ext = {{(ACC_WIDTH-DATA_WIDTH){bias_in[DATA_WIDTH-1]}}, bias_in};
    w_bias_acc = w_bias_ext <<< FRAC_BITS;
    w_rounded  = r_acc + c_half;
    w_shifted  = w_rounded >>> FRAC_BITS;
    if (w_shifted > c_max) begin
      w_sat = c_max[DATA_WIDTH-1:0];
    end else if (w_shifted < c_min) begin
      w_sat = c_min[DATA_WIDTH-1:0];
    end else begin
      w_sat = w_shifted[DATA_WIDTH-1:0];
    end
  end

  // Control FSM with registered accumulator, counter and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_acc    <= '0;
      r_count  <= '0;
      data_out <= '0;
      valid    <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (clear) begin
        // Abort wins over everything; the result register is left alone so
        // downstream still sees the last completed output.
        r_state <= ST_IDLE;
        r_count <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (start) begin
              r_acc   <= w_bias_acc;
              r_count <= '0;
              r_state <= ST_ACCUM;
            end
          end
          ST_ACCUM: begin
            // Without in_valid the accumulation simply stalls.
            if (in_valid) begin
              r_acc   <= r_acc + w_prod_ext;
              r_count <= r_count + CNT_W'(1);
              if (r_count == c_last_term) begin
                r_state <= ST_ROUND;
              end
            end
          end
          ST_ROUND: begin
            data_out <= w_sat;
            valid    <= 1'b1;
            r_state  <= ST_IDLE;
          end
          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  // Busy follows the state register so it drops together with the reset.
  always_comb begin
    busy = (r_state != ST_IDLE);
  end

endmodule
`default_nettype wire

// File: tb/tb_mac_requant.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mac_requant
//  Description : Directed self-checking bench for mac_requant.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mac_requant;

  localparam int DW = 14;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          clear;
  logic          in_valid;
  logic [DW-1:0] act_in;
  logic [DW-1:0] weight_in;
  logic [DW-1:0] bias_in;
  logic [DW-1:0] data_out;
  logic          valid;
  logic          busy;

  int n_cmp;
  int n_err;
  int act_v [9];
  int wt_v  [9];

  mac_requant #(
    .DATA_WIDTH(DW),
    .FRAC_BITS (7),
    .NUM_TERMS (9),
    .ACC_WIDTH (32)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .clear    (clear),
    .in_valid (in_valid),
    .act_in   (act_in),
    .weight_in(weight_in),
    .bias_in  (bias_in),
    .data_out (data_out),
    .valid    (valid),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int dout_int();
    return int'($signed(data_out));
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_all(input int a, input int w);
    for (int i = 0; i < 9; i++) begin
      act_v[i] = a;
      wt_v[i]  = w;
    end
  endtask

  // One complete output: start edge, nine terms (optional stall), round edge.
  task automatic run_output(input int bias, input int stall_at, input int stall_len,
                            input int expected, input string tag);
    start   = 1'b1;
    bias_in = DW'(bias);
    tick();
    start = 1'b0;
    for (int i = 0; i < 9; i++) begin
      in_valid  = 1'b1;
      act_in    = DW'(act_v[i]);
      weight_in = DW'(wt_v[i]);
      tick();
      in_valid = 1'b0;
      if (i + 1 == stall_at) begin
        for (int s = 0; s < stall_len; s++) begin
          check({tag, "_stall_valid"}, int'(valid), 0);
          tick();
        end
        check({tag, "_stall_busy"}, int'(busy), 1);
      end
    end
    check({tag, "_round_valid"}, int'(valid), 0);
    tick();
    check({tag, "_valid"}, int'(valid), 1);
    check({tag, "_data"}, dout_int(), expected);
  endtask

  initial begin
    int seen;
    n_cmp     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    clear     = 1'b0;
    in_valid  = 1'b0;
    act_in    = '0;
    weight_in = '0;
    bias_in   = '0;
    #1;
    check("reset_data", dout_int(), 0);
    check("reset_valid", int'(valid), 0);
    check("reset_busy", int'(busy), 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Nominal 9 x (1.0 * 1.0) = 9.0
    set_all(128, 128);
    run_output(0, 0, 0, 1152, "nominal");
    tick();
    check("nominal_one_cycle", int'(valid), 0);
    check("nominal_hold", dout_int(), 1152);

    // Rounding cases
    set_all(0, 0);
    act_v[0] = 1;
    wt_v[0]  = 64;
    run_output(0, 0, 0, 1, "round_up");
    act_v[0] = -1;
    run_output(0, 0, 0, 0, "round_half_neg");
    set_all(0, 0);
    run_output(-128, 0, 0, -128, "bias_only");

    // Saturation both directions
    set_all(8191, 8191);
    run_output(0, 0, 0, 8191, "sat_pos");
    set_all(-8192, 8191);
    run_output(0, 0, 0, -8192, "sat_neg");

    // Stall after term 4, bias 1.0 -> 10.0
    set_all(128, 128);
    run_output(128, 4, 3, 1280, "stall");

    // Back-to-back: each start lands in the previous valid cycle
    run_output(0, 0, 0, 1152, "b2b_first");
    set_all(256, -64);
    run_output(128, 0, 0, -1024, "b2b_second");

    // Abort after term 5
    set_all(128, 128);
    start   = 1'b1;
    bias_in = '0;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid  = 1'b1;
      act_in    = DW'(act_v[i]);
      weight_in = DW'(wt_v[i]);
      tick();
    end
    in_valid = 1'b0;
    clear    = 1'b1;
    tick();
    clear = 1'b0;
    check("abort_busy", int'(busy), 0);
    check("abort_data", dout_int(), -1024);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (valid) seen++;
      tick();
    end
    check("abort_no_valid", seen, 0);
    clear = 1'b1;
    start = 1'b1;
    tick();
    clear = 1'b0;
    start = 1'b0;
    check("clear_beats_start", int'(busy), 0);

    // Reset mid-accumulation, observed without a clock edge
    start   = 1'b1;
    bias_in = '0;
    tick();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid  = 1'b1;
      act_in    = DW'(act_v[i]);
      weight_in = DW'(wt_v[i]);
      tick();
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset_data", dout_int(), 0);
    check("midreset_valid", int'(valid), 0);
    check("midreset_busy", int'(busy), 0);
    tick();
    rst_n = 1'b1;
    seen  = 0;
    for (int i = 0; i < 12; i++) begin
      if (valid) seen++;
      tick();
    end
    in_valid = 1'b0;
    check("midreset_no_valid", seen, 0);
    run_output(0, 0, 0, 1152, "post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
